// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse-train generator.
package pulse_gen_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int PULSE_GEN_MIN_LEN = 1;
endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one pulse phase; a zero length is clamped to the minimum.
module phase_timer
  import pulse_gen_pkg::*;
#(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic                 i_clr,
  input  logic [LEN_WIDTH-1:0] i_len,
  output logic                 o_expire
);
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] w_len;

  assign w_len = (i_len < LEN_WIDTH'(PULSE_GEN_MIN_LEN)) ? LEN_WIDTH'(PULSE_GEN_MIN_LEN) : i_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            r_cnt <= '0;
    else if (i_clr)          r_cnt <= '0;
    else if (i_load)         r_cnt <= w_len;
    else if (r_cnt != '0)    r_cnt <= r_cnt - LEN_WIDTH'(1);
  end

  // Expiry is flagged during the last clock of the phase so the FSM switches on the following edge.
  assign o_expire = (r_cnt == LEN_WIDTH'(1));
endmodule

// File: rtl/pulse_gen.sv
// Pulse-train generator top: FSM, latched train fields and sent counter.
// Optional abort input enabled by defining PULSE_GEN_ABORT_EN.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int NUM_WIDTH = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [NUM_WIDTH-1:0] i_num,
  input  logic [LEN_WIDTH-1:0] i_high_len,
  input  logic [LEN_WIDTH-1:0] i_low_len,
`ifdef PULSE_GEN_ABORT_EN
  input  logic                 i_abort,
`endif
  output logic                 o_pulse,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NUM_WIDTH-1:0] o_sent
);
  state_t               r_state;
  logic [NUM_WIDTH-1:0] r_num;
  logic [LEN_WIDTH-1:0] r_high;
  logic [LEN_WIDTH-1:0] r_low;
  logic                 r_pulse;
  logic                 r_busy;
  logic                 r_done;
  logic [NUM_WIDTH-1:0] r_sent;

  logic                 w_expire;
  logic                 w_load;
  logic                 w_abort;
  logic                 w_start;
  logic [LEN_WIDTH-1:0] w_len;

`ifdef PULSE_GEN_ABORT_EN
  assign w_abort = i_abort & r_busy;
`else
  assign w_abort = 1'b0;
`endif

  assign w_start = (r_state == ST_IDLE) && i_start && (i_num != '0);

  always_comb begin
    w_load = 1'b0;
    w_len  = i_high_len;
    unique case (r_state)
      ST_IDLE: w_load = w_start;
      ST_HIGH: begin
        w_load = w_expire;
        w_len  = r_low;
      end
      ST_LOW: begin
        w_load = w_expire && (r_sent != r_num);
        w_len  = r_high;
      end
      default: w_load = 1'b0;
    endcase
    if (w_abort) w_load = 1'b0;
  end

  phase_timer #(.LEN_WIDTH(LEN_WIDTH)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_load),
    .i_clr    (w_abort),
    .i_len    (w_len),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_num   <= '0;
      r_high  <= '0;
      r_low   <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sent  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        // Abort wins over a simultaneous expiry, so a truncated high is never counted.
        r_state <= ST_IDLE;
        r_pulse <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_sent <= '0;
              if (i_num != '0) begin
                r_num   <= i_num;
                r_high  <= i_high_len;
                r_low   <= i_low_len;
                r_state <= ST_HIGH;
                r_pulse <= 1'b1;
                r_busy  <= 1'b1;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          ST_HIGH: begin
            if (w_expire) begin
              r_state <= ST_LOW;
              r_pulse <= 1'b0;
              r_sent  <= r_sent + NUM_WIDTH'(1);
            end
          end
          ST_LOW: begin
            if (w_expire) begin
              if (r_sent == r_num) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_HIGH;
                r_pulse <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_pulse = r_pulse;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sent  = r_sent;
endmodule

// File: tb/tb_pulse_gen.sv
// Directed + randomized bench for pulse_gen against an arithmetic train model.
module tb_pulse_gen;
  localparam int NW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] num = '0;
  logic [LW-1:0] hl = '0;
  logic [LW-1:0] ll = '0;
`ifdef PULSE_GEN_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          pulse, busy, done;
  logic [NW-1:0] sent;

  always #5 clk = ~clk;

  pulse_gen #(.NUM_WIDTH(NW), .LEN_WIDTH(LW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_num      (num),
    .i_high_len (hl),
    .i_low_len  (ll),
`ifdef PULSE_GEN_ABORT_EN
    .i_abort    (abort),
`endif
    .o_pulse    (pulse),
    .o_busy     (busy),
    .o_done     (done),
    .o_sent     (sent)
  );

  // Train model: a train accepted at edge S occupies edges S .. S+N*P-1, P = H+L.
  int edgecnt = 0;
  int m_S = -100000, m_N = 0, m_H = 1, m_L = 1;
  bit m_frozen = 1'b0;
  int m_fsent = 0;
  int npass = 0, nfail = 0, ntot = 0;

  function automatic void model(input int e, output bit p, output bit b, output bit d, output int s);
    int rel, per, ph;
    p = 1'b0; b = 1'b0; d = 1'b0; s = 0;
    if (m_frozen) begin
      s = m_fsent;
    end else begin
      rel = e - m_S;
      per = m_H + m_L;
      b = (rel >= 0) && (rel < m_N * per);
      d = (rel == m_N * per);
      if (b) begin
        ph = rel % per;
        p  = (ph < m_H);
        s  = rel / per + ((ph >= m_H) ? 1 : 0);
      end else begin
        s = m_N;
      end
    end
  endfunction

  task automatic model_reset();
    m_S = -100000; m_N = 0; m_H = 1; m_L = 1; m_frozen = 1'b0; m_fsent = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edgecnt, obs, exp);
    end
  endtask

  task automatic tick();
    bit p, b, d;
    int s;
    model(edgecnt, p, b, d, s);
    if (rst_n) begin
`ifdef PULSE_GEN_ABORT_EN
      if (b && abort) begin
        m_frozen = 1'b1;
        m_fsent  = s;
      end
`endif
      if (!b && start) begin
        m_frozen = 1'b0;
        m_S = edgecnt + 1;
        m_N = int'(num);
        m_H = (hl == '0) ? 1 : int'(hl);
        m_L = (ll == '0) ? 1 : int'(ll);
      end
    end
    @(posedge clk);
    edgecnt++;
    @(negedge clk);
    model(edgecnt, p, b, d, s);
    chk("pulse", pulse, p);
    chk("busy", busy, b);
    chk("done", done, d);
    chk("sent", sent, s);
  endtask

  initial begin
    bit p, b, d;
    int s, guard;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // N=3, H=16, L=4
    num = 3; hl = 16; ll = 4; start = 1'b1; tick(); start = 1'b0;
    repeat (64) tick();
    chk("sent_final3", sent, 3);

    // zero-count start
    num = 0; start = 1'b1; tick(); start = 1'b0;
    chk("zero_done", done, 1);
    repeat (3) tick();

    // zero lengths clamp to 1
    num = 2; hl = 0; ll = 0; start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();

    // mid-train start ignored, then back-to-back start on the done cycle
    num = 4; hl = 5; ll = 3; start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    num = 9; hl = 1; ll = 1; start = 1'b1; tick(); start = 1'b0;
    num = 4; hl = 5; ll = 3;
    guard = 0;
    model(edgecnt, p, b, d, s);
    while (!d && guard < 200) begin
      tick(); guard++;
      model(edgecnt, p, b, d, s);
    end
    chk("b2b_done_reached", guard < 200, 1);
    num = 2; hl = 3; ll = 2; start = 1'b1; tick(); start = 1'b0;
    chk("b2b_rise", pulse, 1);
    repeat (12) tick();

    // async reset during second high of a 5-pulse train
    num = 5; hl = 6; ll = 3; start = 1'b1; tick(); start = 1'b0;
    while (edgecnt - m_S < 11) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pulse", pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", sent, 0);
    chk("rst_done", done, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();

`ifdef PULSE_GEN_ABORT_EN
    // abort during third high of five
    num = 5; hl = 4; ll = 2; start = 1'b1; tick(); start = 1'b0;
    while (edgecnt - m_S < 13) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_pulse", pulse, 0);
    chk("abort_sent", sent, 2);
    repeat (4) tick();
`endif

    // randomized churn of every input
    for (int t = 0; t < 3000; t++) begin
      start = ($urandom_range(0, 7) == 0);
      num   = NW'($urandom_range(0, 6));
      hl    = LW'($urandom_range(0, 20));
      ll    = LW'($urandom_range(0, 10));
`ifdef PULSE_GEN_ABORT_EN
      abort = ($urandom_range(0, 60) == 0);
`endif
      tick();
    end
    start = 1'b0;
`ifdef PULSE_GEN_ABORT_EN
    abort = 1'b0;
`endif
    repeat (10) tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
